// File: rtl/regfile_pkg.sv
// Shared constants and types for the parametrised register file with busy scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int AW_DEF    = $clog2(NREGS_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking: issue sets a pending bit, writeback clears it,
// and a running count of pending registers is kept alongside the vector.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = NREGS_DEF,
  localparam int AW    = $clog2(NREGS),
  localparam int CW    = $clog2(NREGS) + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             we_i,
  input  logic [AW-1:0]    wa_i,
  input  logic             issue_valid_i,
  input  logic [AW-1:0]    issue_rd_i,
  output logic             issue_ready_o,
  output logic [NREGS-1:0] busy_o,
  output logic [CW-1:0]    busy_cnt_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             clr, set, inc, dec;

  // A set on the same register as a clear wins, so the count only moves
  // when a bit actually changes state.
  always_comb begin
    clr           = we_i && (wa_i != '0);
    issue_ready_o = !busy_q[issue_rd_i] || (clr && (wa_i == issue_rd_i)) ||
                    (issue_rd_i == '0);
    set           = issue_valid_i && issue_ready_o && (issue_rd_i != '0);
    inc           = set && !busy_q[issue_rd_i];
    dec           = clr && busy_q[wa_i] && !(set && (issue_rd_i == wa_i));
    busy_d        = busy_q;
    if (clr) busy_d[wa_i] = 1'b0;
    if (set) busy_d[issue_rd_i] = 1'b1;
    cnt_d = cnt_q + {{(CW-1){1'b0}}, inc} - {{(CW-1){1'b0}}, dec};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with NRD combinational read ports, one write port and a busy
// scoreboard for RAW/WAW stalls. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS),
  localparam int CW    = $clog2(NREGS) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ra [NRD],
  output logic [XLEN-1:0] rd [NRD],
  output logic [NRD-1:0]  rs_busy,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            issue_ready,
  output logic [CW-1:0]   busy_cnt
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy;

  regfile_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .we_i          (we),
    .wa_i          (wa),
    .issue_valid_i (issue_valid),
    .issue_rd_i    (issue_rd),
    .issue_ready_o (issue_ready),
    .busy_o        (busy),
    .busy_cnt_o    (busy_cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
    end else if (we && (wa != '0)) begin
      regs_q[wa] <= wd;
    end
  end

  // Register 0 reads as zero regardless of array contents.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd[i]      = (ra[i] == '0) ? '0 : regs_q[ra[i]];
      rs_busy[i] = (ra[i] == '0) ? 1'b0 : busy[ra[i]];
`ifdef REGFILE_BYPASS_EN
      if (we && (wa != '0) && (ra[i] == wa)) begin
        rd[i]      = wd;
        rs_busy[i] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: a reference model pushes expected outputs
// into a queue as each cycle is driven; the queue is drained against the DUT.
module tb_regfile_sb;
  import regfile_pkg::*;

  logic      clk = 1'b0;
  logic      rst_n;
  reg_addr_t ra [2];
  xword_t    rd [2];
  logic [1:0] rs_busy;
  logic      we;
  reg_addr_t wa;
  xword_t    wd;
  logic      issue_valid;
  reg_addr_t issue_rd;
  logic      issue_ready;
  logic [5:0] busy_cnt;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ra          (ra),
    .rd          (rd),
    .rs_busy     (rs_busy),
    .we          (we),
    .wa          (wa),
    .wd          (wd),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .busy_cnt    (busy_cnt)
  );

  typedef struct {
    int          kind;
    logic [31:0] value;
    string       tag;
  } expect_t;

  expect_t expQ[$];
  xword_t  mRegs [32];
  logic    mBusy [32];
  bit      modelValid = 1'b0;
  int      assertCount = 0;
  int      failCount = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int popBusy();
    int n = 0;
    for (int r = 0; r < 32; r++) if (mBusy[r]) n++;
    return n;
  endfunction

  function automatic logic modelReady();
    return !mBusy[issue_rd] || (we && (wa == issue_rd) && (wa != 0)) || (issue_rd == 0);
  endfunction

  task automatic pushExp(input int kind, input logic [31:0] v, input string tag);
    expect_t e;
    e.kind  = kind;
    e.value = v;
    e.tag   = tag;
    expQ.push_back(e);
  endtask

  // Drive one cycle of inputs and queue the model's view of the combinational outputs.
  task automatic applyStimulus(input logic rstv, input logic wev, input reg_addr_t wav,
                               input xword_t wdv, input logic ivv, input reg_addr_t irv,
                               input reg_addr_t r0, input reg_addr_t r1);
    xword_t expRd;
    logic   expBusy;
    @(negedge clk);
    rst_n = rstv; we = wev; wa = wav; wd = wdv;
    issue_valid = ivv; issue_rd = irv; ra[0] = r0; ra[1] = r1;
    if (modelValid) begin
      for (int i = 0; i < 2; i++) begin
        expRd   = (ra[i] == 0) ? 32'h0 : mRegs[ra[i]];
        expBusy = (ra[i] == 0) ? 1'b0 : mBusy[ra[i]];
`ifdef REGFILE_BYPASS_EN
        if (we && (wa != 0) && (ra[i] == wa)) begin
          expRd   = wd;
          expBusy = 1'b0;
        end
`endif
        pushExp(i, expRd, (i == 0) ? "rd0" : "rd1");
        pushExp(2 + i, {31'b0, expBusy}, (i == 0) ? "busy0" : "busy1");
      end
      pushExp(4, {31'b0, modelReady()}, "ready");
      pushExp(5, 32'(popBusy()), "cnt");
    end
  endtask

  // Compare queued expectations, then clock the DUT and advance the model.
  task automatic finishCycle();
    expect_t     e;
    logic [31:0] obs;
    logic        rdy;
    #1;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      case (e.kind)
        0:       obs = rd[0];
        1:       obs = rd[1];
        2:       obs = {31'b0, rs_busy[0]};
        3:       obs = {31'b0, rs_busy[1]};
        4:       obs = {31'b0, issue_ready};
        default: obs = {26'b0, busy_cnt};
      endcase
      checkOutput(e.tag, obs, e.value);
    end
    @(posedge clk);
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        mRegs[r] = '0;
        mBusy[r] = 1'b0;
      end
      modelValid = 1'b1;
    end else if (modelValid) begin
      rdy = modelReady();
      if (we && (wa != 0)) begin
        mRegs[wa] = wd;
        mBusy[wa] = 1'b0;
      end
      if (issue_valid && rdy && (issue_rd != 0)) mBusy[issue_rd] = 1'b1;
    end
  endtask

  initial begin
    // Reset, then idle read of x5/x0
    applyStimulus(0, 1, 5, 32'hFFFF_FFFF, 1, 6, 5, 0); finishCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 5, 0); finishCycle();
    applyStimulus(1, 0, 0, 0, 0, 5, 5, 0);
    pushExp(0, 32'h0, "rst_rd0"); pushExp(1, 32'h0, "rst_rd1");
    pushExp(2, 32'h0, "rst_busy0"); pushExp(5, 32'h0, "rst_cnt"); pushExp(4, 32'h1, "rst_ready");
    finishCycle();

    // Write and read back, x0 write ignored
    applyStimulus(1, 1, 5, 32'hDEAD_BEEF, 0, 0, 5, 0); finishCycle();
    applyStimulus(1, 1, 0, 32'h0000_1234, 0, 0, 5, 0);
    pushExp(0, 32'hDEAD_BEEF, "wr_rd5");
    finishCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 5, 0);
    pushExp(1, 32'h0, "x0_rd");
    finishCycle();

    // Scoreboard lifecycle on x7
    applyStimulus(1, 0, 0, 0, 1, 7, 7, 0); finishCycle();
    applyStimulus(1, 0, 0, 0, 1, 7, 7, 0);
    pushExp(2, 32'h1, "x7_busy"); pushExp(5, 32'h1, "x7_cnt"); pushExp(4, 32'h0, "waw_ready");
    finishCycle();
    applyStimulus(1, 1, 7, 32'h55, 0, 0, 7, 0); finishCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 7, 0);
    pushExp(5, 32'h0, "x7_clr_cnt"); pushExp(0, 32'h55, "x7_rd");
    finishCycle();

    // Same-cycle clear and set on x3
    applyStimulus(1, 0, 0, 0, 1, 3, 3, 0); finishCycle();
    applyStimulus(1, 1, 3, 32'h33, 1, 3, 3, 0);
    pushExp(4, 32'h1, "setclr_ready");
    finishCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 3, 0);
    pushExp(2, 32'h1, "setclr_busy"); pushExp(5, 32'h1, "setclr_cnt"); pushExp(0, 32'h33, "setclr_rd");
    finishCycle();
    applyStimulus(1, 1, 3, 32'h34, 0, 0, 3, 0); finishCycle();

    // Write-to-read forwarding on x9
    applyStimulus(1, 1, 9, 32'h1111_1111, 0, 0, 9, 0); finishCycle();
    applyStimulus(1, 1, 9, 32'hA5A5_A5A5, 0, 0, 9, 0);
`ifdef REGFILE_BYPASS_EN
    pushExp(0, 32'hA5A5_A5A5, "bypass_rd");
`else
    pushExp(0, 32'h1111_1111, "nobypass_rd");
`endif
    finishCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 9, 0);
    pushExp(0, 32'hA5A5_A5A5, "post_wr_rd");
    finishCycle();

    // Fill every busy bit, then reset with a coincident write and issue
    for (int r = 1; r < 32; r++) begin
      applyStimulus(1, 0, 0, 0, 1, reg_addr_t'(r), reg_addr_t'(r), 0);
      finishCycle();
    end
    applyStimulus(1, 0, 0, 0, 1, 0, 4, 31);
    pushExp(5, 32'd31, "full_cnt"); pushExp(4, 32'h1, "x0_issue_ready");
    finishCycle();
    applyStimulus(0, 1, 4, 32'hCAFE_F00D, 1, 4, 4, 7); finishCycle();
    applyStimulus(1, 0, 0, 0, 0, 12, 4, 7);
    pushExp(5, 32'h0, "midrst_cnt"); pushExp(0, 32'h0, "midrst_rd4");
    pushExp(1, 32'h0, "midrst_rd7"); pushExp(2, 32'h0, "midrst_busy4");
    finishCycle();

    // Random traffic over a small register window to provoke collisions
    for (int n = 0; n < 80; n++) begin
      applyStimulus(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
                    reg_addr_t'($urandom_range(0, 7)), xword_t'($urandom()),
                    1'($urandom_range(0, 1)), reg_addr_t'($urandom_range(0, 7)),
                    reg_addr_t'($urandom_range(0, 7)), reg_addr_t'($urandom_range(0, 7)));
      finishCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's single-write, two-read register file.
- Adds a synchronous active-low reset, a configurable number of read ports and register count, a per-register busy scoreboard and an outstanding-write counter.
- Sits between decode/issue and writeback of the pipelined RV32 core.
- Issue marks a destination register pending; writeback clears it. Decode uses the busy flags for RAW/WAW stall decisions.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers, power of two ≥ 2. Register 0 is hardwired to zero.
- NRD, 2, number of combinational read ports.
- AW (localparam), $clog2(NREGS), register address width.
- CW (localparam), $clog2(NREGS)+1, outstanding-counter width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- ra  in  NRD×AW  read addresses, unpacked array [NRD].
- rd  out  NRD×XLEN  read data per port.
- rs_busy  out  NRD  busy flag of the register addressed on each read port.
- we  in  1  writeback valid.
- wa  in  AW  writeback address.
- wd  in  XLEN  writeback data.
- issue_valid  in  1  issue request marking issue_rd pending.
- issue_rd  in  AW  destination being issued.
- issue_ready  out  1  issue can be accepted this cycle.
- busy_cnt  out  CW  number of registers currently busy.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n), sampled only on the clk rising edge.
- Reset (rst_n=0 at a posedge):
  - all registers := 0, all busy bits := 0, busy_cnt := 0.
  - Overrides any we or issue_valid in the same cycle.
  - Reset mid-operation discards all pending state; nothing is retained.
- Write:
  - On posedge with we=1 and wa≠0: reg[wa] := wd and busy[wa] := 0.
  - we with wa=0 is ignored entirely.
- Read:
  - Combinational, zero latency.
  - rd[i] = 0 when ra[i]=0, otherwise reg[ra[i]] (see bypass option).
  - rs_busy[i] = busy[ra[i]]; always 0 for register 0.
- Issue:
  - issue_ready = !busy[issue_rd] || (we && wa==issue_rd && wa≠0) || issue_rd==0.
  - Accepted when issue_valid && issue_ready.
  - Acceptance with issue_rd≠0 sets busy[issue_rd] := 1 at the next posedge.
  - issue_valid while issue_ready=0 has no effect; the requester holds and retries (WAW stall).
  - issue_rd=0 is always accepted and sets no busy bit.
- Simultaneous writeback clear and accepted issue to the same register: the set wins, so busy stays 1. The write data still lands in the array.
- busy_cnt:
  - Updated by the same-cycle delta: +1 on a set of a previously clear bit, −1 on a clear of a previously set bit, net 0 for same-register set+clear.
  - Invariant: busy_cnt == popcount(busy) at every cycle.
  - Maximum value is NREGS−1; never wraps.
- Writeback to a non-busy register is legal: data is written, busy stays 0, count is unchanged.

Optional Feature:
- Macro REGFILE_BYPASS_EN.
- Defined: when we=1, wa≠0 and ra[i]==wa in the same cycle, rd[i]=wd and rs_busy[i]=0, unless an accepted issue targets that same register this cycle. That exception affects only the next cycle, so rs_busy[i]=0 still holds now. Gives write-to-read forwarding with no decode stall on the writeback cycle.
- Undefined: rd[i] and rs_busy[i] reflect registered state only. The new value and the cleared busy bit become visible the cycle after the write.

Decomposition:
- Package regfile_pkg holds:
  - default XLEN/NREGS constants;
  - typedef reg_addr_t = logic [AW-1:0] for the default configuration;
  - typedef xword_t = logic [XLEN-1:0].
- One natural sub-module, regfile_scoreboard: busy vector, issue_ready logic and busy_cnt.
- The data array and read muxing stay in regfile_sb.

Test Plan:
- Reset then read: rst_n=0 for 2 cycles, release, ra={5,0} -> rd={0,0}, rs_busy=0, busy_cnt=0, issue_ready=1.
- Write/read and x0: we, wa=5, wd=0xDEADBEEF, then ra[0]=5 -> rd[0]=0xDEADBEEF. Then we, wa=0, wd=0x1234, ra[1]=0 -> rd[1]=0.
- Scoreboard lifecycle:
  - issue_rd=7 accepted -> next cycle rs_busy=1 for ra=7, busy_cnt=1.
  - issue_rd=7 again -> issue_ready=0.
  - we, wa=7, wd=0x55 -> next cycle busy_cnt=0, rd=0x55.
- Same-cycle set and clear: x3 busy; we, wa=3 together with issue_rd=3 -> issue_ready=1, busy[3] stays 1, busy_cnt unchanged at 1, reg[3]=wd.
- Bypass (REGFILE_BYPASS_EN): we, wa=9, wd=0xA5A5A5A5 with ra[0]=9 -> same-cycle rd[0]=0xA5A5A5A5, rs_busy[0]=0. Without the macro -> old value this cycle, new value next cycle.
- Mid-operation reset: fill 31 busy bits (busy_cnt=31), assert rst_n=0 with a coincident we and issue -> next cycle busy_cnt=0, all reads return 0.
